// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg -- shared types and constants for the FIFO read-port drainer.
//   occ_t      : skid-buffer occupancy (EMPTY/ONE/TWO); encoding equals word count.
//   RD_COUNT_W : width of the optional delivered-word counter.
//   occ_count  : occupancy state to word count.
package fifo_reader_pkg;

  localparam int unsigned RD_COUNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  function automatic logic [1:0] occ_count(input occ_t occ);
    logic [1:0] n;
    case (occ)
      EMPTY:   n = 2'd0;
      ONE:     n = 2'd1;
      TWO:     n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// fifo_reader_if -- FIFO read port plus downstream valid/ready stream.
//   fifo_empty  : FIFO empty flag                       (FIFO -> reader)
//   read_data   : FIFO word, valid cycle after a read   (FIFO -> reader)
//   read_enable : FIFO pop request                      (reader -> FIFO)
//   out_valid   : downstream word available            (reader -> sink)
//   out_ready   : downstream accepts word               (sink -> reader)
//   out_data    : downstream word                       (reader -> sink)
// master modport: the reader; slave modport: the FIFO/sink environment.
interface fifo_reader_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_enable;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    input  fifo_empty, read_data, out_ready,
    output read_enable, out_valid, out_data
  );

  modport slave (
    output fifo_empty, read_data, out_ready,
    input  read_enable, out_valid, out_data
  );
endinterface

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid -- 2-entry skid buffer with occupancy FSM.
//   clock, reset  : rising-edge clock, async active-high reset
//   i_push        : write i_push_data (captured FIFO word)
//   i_pop         : head word consumed downstream
//   o_occupancy   : EMPTY / ONE / TWO
//   o_head        : oldest buffered word
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output occ_t                  o_occupancy,
  output logic [DATA_WIDTH-1:0] o_head
);

  occ_t                  r_occ;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_occ  <= EMPTY;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_occ)
        EMPTY: begin
          if (i_push) begin
            r_head <= i_push_data;
            r_occ  <= ONE;
          end
        end
        ONE: begin
          case ({i_push, i_pop})
            2'b10: begin
              r_tail <= i_push_data;
              r_occ  <= TWO;
            end
            2'b01: r_occ <= EMPTY;
            2'b11: r_head <= i_push_data;
            default: ;
          endcase
        end
        TWO: begin
          // Push+pop here cannot occur upstream, but is handled as a shift
          // so correctness does not hinge on that.
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) r_tail <= i_push_data;
            else        r_occ  <= ONE;
          end
        end
        default: r_occ <= EMPTY;
      endcase
    end
  end

  assign o_occupancy = r_occ;
  assign o_head      = r_head;

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader -- drains a FIFO read port into a valid/ready stream, in order.
//   clock    : rising-edge clock
//   reset    : asynchronous, active-high reset
//   bus      : fifo_reader_if.master (FIFO read port + downstream stream)
//   rd_count : words delivered downstream, wraps at 16 bits
//              (present only when FIFO_READER_STATS_EN is defined)
// A read issued in cycle N returns data in N+1; r_inflight remembers that a
// word is arriving so the 2-entry skid buffer can never be overrun.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  fifo_reader_if.master         bus
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [RD_COUNT_W-1:0] rd_count
`endif
);

  logic                  r_run;
  logic                  r_inflight;
  occ_t                  w_occ;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_valid;
  logic                  w_pop;
  logic [2:0]            w_level;
  logic                  w_read_enable;

  assign w_valid = (w_occ != EMPTY);
  assign w_pop   = w_valid && bus.out_ready;

  // Projected occupancy after this cycle; a read is only safe below 2.
  assign w_level = {1'b0, occ_count(w_occ)} + {2'b00, r_inflight} - {2'b00, w_pop};

  // r_run holds reads off until the first edge after reset release.
  assign w_read_enable = r_run && !bus.fifo_empty && (w_level < 3'd2);

  assign bus.read_enable = w_read_enable;
  assign bus.out_valid   = w_valid;
  assign bus.out_data    = w_head;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run      <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_read_enable;
    end
  end

  fifo_reader_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clock       (clock),
    .reset       (reset),
    .i_push      (r_inflight),
    .i_push_data (bus.read_data),
    .i_pop       (w_pop),
    .o_occupancy (w_occ),
    .o_head      (w_head)
  );

`ifdef FIFO_READER_STATS_EN
  logic [RD_COUNT_W-1:0] r_rd_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      r_rd_count <= '0;
    else if (w_pop) r_rd_count <= r_rd_count + 1'b1;
  end

  assign rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
`timescale 1ns/1ps
module tb_fifo_reader;

  localparam int unsigned DW = 8;

  logic clock;
  logic reset;

  fifo_reader_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FIFO_READER_STATS_EN
  logic [15:0] rd_count;
`endif

  fifo_reader #(.DATA_WIDTH(DW)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus)
`ifdef FIFO_READER_STATS_EN
    ,
    .rd_count (rd_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // FIFO contents not yet read, and the expected downstream sequence.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            n_cmp   = 0;
  int            n_fail  = 0;
  int            n_read  = 0;
  int            n_deliv = 0;
  int            n_lost  = 0;
  int            ready_mode = 1;   // 0 low, 1 high, 2 random 50%
  bit            hold_empty = 1'b0;
  logic [15:0]   pop_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic update_empty();
    bus.fifo_empty = (fifo_q.size() == 0) || hold_empty;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    update_empty();
  endtask

  task automatic set_ready(input int m);
    ready_mode = m;
    bus.out_ready = (m == 1) ? 1'b1 : (m == 0) ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic sample();
    @(negedge clock);
    #2;
  endtask

  // Reset discards every word already taken from the FIFO but not delivered.
  task automatic do_reset(input int cycles);
    int lost;
    @(posedge clock);
    #3;
    reset = 1'b1;
    lost = n_read - n_deliv;
    for (int i = 0; i < lost; i++) void'(exp_q.pop_front());
    n_lost += lost;
    n_read  = n_deliv;
    pop_cnt = '0;
    #1;
    check("rst_read_enable", bus.read_enable, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    repeat (cycles) @(posedge clock);
    #3;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      step();
      c++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // FIFO model: a read accepted in cycle N shows its word in N+1.
  initial begin
    bit pend;
    forever begin
      @(negedge clock);
      check("re_while_empty", bus.read_enable && bus.fifo_empty, 0);
      pend = bus.read_enable && !bus.fifo_empty && !reset;
      @(posedge clock);
      #1;
      if (pend && fifo_q.size() > 0) begin
        bus.read_data = fifo_q.pop_front();
        n_read++;
      end else begin
        bus.read_data = DW'($urandom);
      end
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      update_empty();
    end
  end

  // Scoreboard monitor: any presented word must be the oldest expected one.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          check("out_data", bus.out_data, exp_q[0]);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            n_deliv++;
`ifdef FIFO_READER_STATS_EN
            check("rd_count", rd_count, pop_cnt);
            pop_cnt = pop_cnt + 16'd1;
`endif
          end
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, n_deliv=%0d", n_deliv);
    $fatal(1, "watchdog");
  end

  initial begin
    bit            exp_re [7] = '{0, 1, 1, 1, 0, 0, 0};
    bit            exp_v  [7] = '{0, 0, 0, 1, 1, 1, 0};
    logic [DW-1:0] exp_d  [7] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    logic [DW-1:0] first;
    int            base_read, base_deliv, base_lost, cyc;

    reset = 1'b0;
    bus.read_data = '0;
    bus.out_ready = 1'b1;
    hold_empty = 1'b0;
    update_empty();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    #1 reset = 1'b1;
    #2;
    check("reset_read_enable", bus.read_enable, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b0;

    // Preloaded 3 words, ready high: first sample is the cycle before cycle 0.
    for (int c = 0; c < 7; c++) begin
      sample();
      check("t3w_read_enable", bus.read_enable, exp_re[c]);
      check("t3w_out_valid", bus.out_valid, exp_v[c]);
      if (exp_v[c]) check("t3w_out_data", bus.out_data, exp_d[c]);
    end

    // Back-pressure: exactly two reads, head word held.
    step();
    set_ready(0);
    base_read  = n_read;
    base_deliv = n_deliv;
    first = DW'($urandom);
    push_word(first);
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    repeat (8) step();
    check("bp_reads", n_read - base_read, 2);
    sample();
    check("bp_out_valid", bus.out_valid, 1);
    check("bp_out_data", bus.out_data, first);
    step();
    set_ready(1);
    for (int c = 0; c < 5; c++) begin
      sample();
      check("bp_stream_xfer", bus.out_valid && bus.out_ready, 1);
    end
    sample();
    check("bp_after_valid", bus.out_valid, 0);
    check("bp_delivered", n_deliv - base_deliv, 5);

    // Reset while holding two words: buffered words are dropped.
    step();
    set_ready(0);
    base_deliv = n_deliv;
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    repeat (6) step();
    sample();
    check("rst2_pre_valid", bus.out_valid, 1);
    do_reset(2);
    step();
    set_ready(1);
    wait_drain("rst2_drain", 50);
    check("rst2_delivered", n_deliv - base_deliv, 2);

    // FIFO runs dry after one word, refills three cycles later.
    step();
    base_deliv = n_deliv;
    push_word(DW'($urandom));
    repeat (4) step();
    check("gap_one_word", n_deliv - base_deliv, 1);
    sample();
    check("gap_out_valid", bus.out_valid, 0);
    step();
    for (int i = 0; i < 4; i++) push_word(DW'($urandom));
    wait_drain("gap_drain", 50);
    check("gap_delivered", n_deliv - base_deliv, 5);

    // Empty flag rises mid-stream: read_enable drops the same cycle.
    step();
    base_deliv = n_deliv;
    for (int i = 0; i < 8; i++) push_word(DW'($urandom));
    step();
    step();
    hold_empty = 1'b1;
    update_empty();
    #1;
    check("midempty_read_enable", bus.read_enable, 0);
    repeat (3) step();
    hold_empty = 1'b0;
    update_empty();
    wait_drain("midempty_drain", 100);
    check("midempty_delivered", n_deliv - base_deliv, 8);

    // Random words, random ready, two resets mid-stream.
    step();
    set_ready(2);
    base_deliv = n_deliv;
    base_lost  = n_lost;
    cyc = 0;
    for (int i = 0; i < 1000; ) begin
      step();
      cyc++;
      if (cyc == 400 || cyc == 1300) begin
        do_reset(1);
      end else if (fifo_q.size() < 6 && $urandom_range(0, 3) != 0) begin
        push_word(DW'($urandom));
        i++;
      end
    end
    wait_drain("rand_drain", 5000);
    check("rand_accounted", (n_deliv - base_deliv) + (n_lost - base_lost), 1000);

`ifdef FIFO_READER_STATS_EN
    // 65537 pops from reset wraps the counter to 1.
    do_reset(1);
    step();
    set_ready(1);
    for (int pushed = 0; pushed < 65537; ) begin
      step();
      if (fifo_q.size() < 4) begin
        push_word(DW'($urandom));
        pushed++;
      end
    end
    wait_drain("stats_drain", 200);
    sample();
    check("stats_rd_count", rd_count, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
